sram_ring_scheduler: RTL and testbench
======================================

SRAM_RING_SCHEDULER -- requirements
Module: sram_ring_scheduler

Interface
REQ-001 Parameter ADDR_W, 14, SRAM word-address width; DEPTH = 2^ADDR_W words.
REQ-002 Parameter WR_BURST, 1024, words per write burst; power of two, at most DEPTH.
REQ-003 Parameter RD_BURST, 4096, maximum words per read burst; power of two, at most DEPTH.
REQ-004 Parameter IN_USEDW_W, 11, width of the input-FIFO used-word count.
REQ-005 Parameter OUT_USEDW_W, 14, width of the output-FIFO used-word count.
REQ-006 Parameter OUT_MAX_USED, 12288, maximum output-FIFO fill at which a read may be issued.
REQ-007 Parameter TIMEOUT, 65535, maximum cycles spent in a wait state before an error.
REQ-008 clk  in  1  single clock; all state changes on its rising edge.
REQ-009 reset  in  1  asynchronous, active-high reset.
REQ-010 iRunStart  in  1  run level; high = acquire, falling = stop and flush.
REQ-011 SRAM_FIFO_usedw  in  IN_USEDW_W  input-FIFO used words.
REQ-012 USB_FIFO_usedw  in  OUT_USEDW_W  output-FIFO used words.
REQ-013 WR_RunEnd / RD_RunEnd  in  1 each  one-cycle completion pulses from the SRAM write and read engines.
REQ-014 WR_iRunStart / RD_iRunStart  out  1 each  one-cycle burst start pulses.
REQ-015 WR_START_ADDR / RD_START_ADDR  out  ADDR_W each  burst start addresses.
REQ-016 WR_DATA_NUM / RD_DATA_NUM  out  ADDR_W+1 each  burst lengths.
REQ-017 Data_iRunStart  out  1  data-source enable.
REQ-018 SRAM_USED_WORD  out  ADDR_W+1  words currently held in SRAM.
REQ-019 SRAM_Full / SRAM_Empty  out  1 each  SRAM_USED_WORD > DEPTH-WR_BURST / SRAM_USED_WORD == 0; combinational from the register.
REQ-020 Timeout_Err  out  1  sticky wait-state timeout flag.

Function
REQ-021 The SRAM SHALL operate as a circular buffer: write and read pointers advance modulo DEPTH, and write and read bursts interleave during a run.
REQ-022 The FSM SHALL have the states IDLE, ARB, WR_WAIT, RD_WAIT and DRAIN_CHK.
REQ-023 IDLE: both start pulses 0. When iRunStart=1: clear both pointers, SRAM_USED_WORD and Timeout_Err; set Data_iRunStart=1; go to ARB.
REQ-024 In any non-IDLE state, iRunStart=0 SHALL clear Data_iRunStart and set an internal drain flag; drain stays set until IDLE.
REQ-025 Write-eligible = Data_iRunStart=1, SRAM_FIFO_usedw >= WR_BURST and DEPTH-SRAM_USED_WORD >= WR_BURST.
REQ-026 Read-eligible = USB_FIFO_usedw <= OUT_MAX_USED and either SRAM_USED_WORD >= RD_BURST, or drain=1 with SRAM_USED_WORD > 0.
REQ-027 ARB, only write-eligible: issue a write. ARB, only read-eligible: issue a read. ARB, both eligible: grant the type not granted last; the last-grant register resets to "read", so a write wins the first tie.
REQ-028 ARB, neither eligible with drain=1: go to DRAIN_CHK. ARB, neither eligible with drain=0: stay in ARB.
REQ-029 Write issue, in one cycle: WR_iRunStart=1; WR_DATA_NUM=WR_BURST; WR_START_ADDR=write pointer; go to WR_WAIT.
REQ-030 Read issue, in one cycle: RD_iRunStart=1; RD_DATA_NUM=min(SRAM_USED_WORD, RD_BURST); RD_START_ADDR=read pointer; go to RD_WAIT.
REQ-031 Each start pulse SHALL be exactly one cycle wide, cleared in the cycle after issue.
REQ-032 WR_WAIT, on WR_RunEnd: write pointer += WR_DATA_NUM mod DEPTH; SRAM_USED_WORD += WR_DATA_NUM; go to ARB.
REQ-033 RD_WAIT, on RD_RunEnd: read pointer += RD_DATA_NUM mod DEPTH; SRAM_USED_WORD -= RD_DATA_NUM; go to ARB.
REQ-034 RunEnd pulses outside their matching wait state SHALL be ignored.
REQ-035 SRAM_USED_WORD SHALL never exceed DEPTH and never underflow.
REQ-036 DRAIN_CHK: if SRAM_USED_WORD==0, go to IDLE; otherwise go to ARB.
REQ-037 A wait-cycle counter SHALL clear on entry to WR_WAIT/RD_WAIT; reaching TIMEOUT without the matching RunEnd sets Timeout_Err, clears Data_iRunStart and forces IDLE, leaving counters unchanged.
REQ-038 iRunStart toggling while in a wait state SHALL NOT abort the burst in progress.

Reset
REQ-039 Asserting reset SHALL immediately put every output and register at 0: state IDLE, pointers, SRAM_USED_WORD, DATA_NUMs, start pulses, Data_iRunStart, Timeout_Err, drain flag and wait counter.
REQ-040 Consequently SRAM_Empty=1 and SRAM_Full=0 during reset.
REQ-041 Reset asserted mid-burst SHALL abandon the burst; the first activity after release requires iRunStart=1 in IDLE.

Verification
REQ-042 iRunStart=1, SRAM_FIFO_usedw=1024, write engine ends 10 cycles after each pulse -> WR_iRunStart one cycle wide; WR_START_ADDR 0, 1024, 2048, 3072; SRAM_USED_WORD reaches 4096; then a read at RD_START_ADDR=0 with RD_DATA_NUM=4096.
REQ-043 Both writes and reads continuously eligible -> grants alternate W,R,W,R; the write pointer wraps from 15360 to 0 without a glitch.
REQ-044 USB_FIFO_usedw=12289 with 16384 words stored -> no RD_iRunStart, no write, SRAM_Full=1; lowering USB_FIFO_usedw to 12288 -> a read issues the next cycle.
REQ-045 iRunStart falls with 1024 words stored -> Data_iRunStart=0; one read with RD_DATA_NUM=1024; after its RD_RunEnd, DRAIN_CHK then IDLE, SRAM_Empty=1.
REQ-046 TIMEOUT=100, no WR_RunEnd -> Timeout_Err=1 at wait cycle 100, state IDLE; a later iRunStart clears it.
REQ-047 reset pulsed during RD_WAIT -> all outputs 0 at once; a stray RD_RunEnd after release has no effect.

Source files
------------

// File: rtl/sram_ring_scheduler.sv
// sram_ring_scheduler
//   Schedules write and read bursts into an external SRAM used as a circular buffer.
//   Write bursts move WR_BURST words from the input FIFO into SRAM. Read bursts move up to
//   RD_BURST words from SRAM into the output FIFO. When both are possible the grant alternates.
//   A falling iRunStart stops data acquisition and drains SRAM before the block returns to idle.
//
// Ports
//   clk, reset                       clock, asynchronous active-high reset
//   iRunStart                        run level: high = acquire, falling = stop and flush
//   SRAM_FIFO_usedw / USB_FIFO_usedw input / output FIFO fill levels
//   WR_RunEnd / RD_RunEnd            one-cycle completion pulses from the SRAM engines
//   WR_iRunStart / RD_iRunStart      one-cycle burst start pulses
//   WR_START_ADDR / RD_START_ADDR    burst start addresses
//   WR_DATA_NUM / RD_DATA_NUM        burst lengths
//   Data_iRunStart                   data-source enable
//   SRAM_USED_WORD                   words currently held in SRAM
//   SRAM_Full / SRAM_Empty           fill flags derived from SRAM_USED_WORD
//   Timeout_Err                      sticky wait-state timeout flag
module sram_ring_scheduler #(
   parameter int unsigned ADDR_W       = 14,
   parameter int unsigned WR_BURST     = 1024,
   parameter int unsigned RD_BURST     = 4096,
   parameter int unsigned IN_USEDW_W   = 11,
   parameter int unsigned OUT_USEDW_W  = 14,
   parameter int unsigned OUT_MAX_USED = 12288,
   parameter int unsigned TIMEOUT      = 65535
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   iRunStart,
   input  logic [IN_USEDW_W-1:0]  SRAM_FIFO_usedw,
   input  logic [OUT_USEDW_W-1:0] USB_FIFO_usedw,
   input  logic                   WR_RunEnd,
   input  logic                   RD_RunEnd,
   output logic                   WR_iRunStart,
   output logic                   RD_iRunStart,
   output logic [ADDR_W-1:0]      WR_START_ADDR,
   output logic [ADDR_W-1:0]      RD_START_ADDR,
   output logic [ADDR_W:0]        WR_DATA_NUM,
   output logic [ADDR_W:0]        RD_DATA_NUM,
   output logic                   Data_iRunStart,
   output logic [ADDR_W:0]        SRAM_USED_WORD,
   output logic                   SRAM_Full,
   output logic                   SRAM_Empty,
   output logic                   Timeout_Err
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W:0] WR_NUM = (ADDR_W + 1)'(WR_BURST);
   localparam logic [ADDR_W:0] RD_NUM = (ADDR_W + 1)'(RD_BURST);

   typedef enum logic [2:0] {StIdle, StArb, StWrWait, StRdWait, StDrainChk} state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]    used_q, used_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
   logic [ADDR_W:0]    wr_num_q, wr_num_d;
   logic [ADDR_W:0]    rd_num_q, rd_num_d;
   logic               wr_start_q, wr_start_d;
   logic               rd_start_q, rd_start_d;
   logic               run_q, run_d;
   logic               drain_q, drain_d;
   logic               terr_q, terr_d;
   logic               last_wr_q, last_wr_d;  // 0 = last grant was a read
   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

   logic [31:0]        used_ext;
   logic [31:0]        used_plus_wr;
   logic [ADDR_W:0]    used_after_wr;
   logic [ADDR_W:0]    used_after_rd;
   logic [ADDR_W:0]    rd_len;
   logic               wr_elig;
   logic               rd_elig;
   logic               timeout_hit;

   assign used_ext = 32'(used_q);

   assign wr_elig = run_q && (32'(SRAM_FIFO_usedw) >= WR_BURST) && (DEPTH - used_ext >= WR_BURST);
   assign rd_elig = (32'(USB_FIFO_usedw) <= OUT_MAX_USED) &&
                    ((used_ext >= RD_BURST) || (drain_q && (used_q != '0)));

   // A draining read may be shorter than RD_BURST.
   assign rd_len = (used_ext < RD_BURST) ? used_q : RD_NUM;

   // Fill arithmetic clamps at DEPTH and zero so a stray length can never wrap the count.
   assign used_plus_wr  = used_ext + 32'(wr_num_q);
   assign used_after_wr = (used_plus_wr > DEPTH) ? (ADDR_W + 1)'(DEPTH)
                                                 : (ADDR_W + 1)'(used_plus_wr);
   assign used_after_rd = (used_q > rd_num_q) ? (used_q - rd_num_q) : '0;

   // wait_cnt_q counts completed wait cycles, so this is the TIMEOUT-th one.
   assign timeout_hit = (32'(wait_cnt_q) == TIMEOUT - 1);

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      used_d     = used_q;
      wr_addr_d  = wr_addr_q;
      rd_addr_d  = rd_addr_q;
      wr_num_d   = wr_num_q;
      rd_num_d   = rd_num_q;
      wr_start_d = 1'b0;
      rd_start_d = 1'b0;
      run_d      = run_q;
      drain_d    = drain_q;
      terr_d     = terr_q;
      last_wr_d  = last_wr_q;
      wait_cnt_d = wait_cnt_q;

      unique case (state_q)
         StIdle: begin
            drain_d = 1'b0;
            if (iRunStart) begin
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               used_d   = '0;
               terr_d   = 1'b0;
               run_d    = 1'b1;
               state_d  = StArb;
            end
         end
         StArb: begin
            if (wr_elig && (!rd_elig || !last_wr_q)) begin
               wr_start_d = 1'b1;
               wr_num_d   = WR_NUM;
               wr_addr_d  = wr_ptr_q;
               last_wr_d  = 1'b1;
               wait_cnt_d = '0;
               state_d    = StWrWait;
            end else if (rd_elig) begin
               rd_start_d = 1'b1;
               rd_num_d   = rd_len;
               rd_addr_d  = rd_ptr_q;
               last_wr_d  = 1'b0;
               wait_cnt_d = '0;
               state_d    = StRdWait;
            end else if (drain_q) begin
               state_d = StDrainChk;
            end
         end
         StWrWait: begin
            if (WR_RunEnd) begin
               wr_ptr_d = wr_ptr_q + wr_num_q[ADDR_W-1:0];
               used_d   = used_after_wr;
               state_d  = StArb;
            end else if (timeout_hit) begin
               terr_d  = 1'b1;
               run_d   = 1'b0;
               state_d = StIdle;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         StRdWait: begin
            if (RD_RunEnd) begin
               rd_ptr_d = rd_ptr_q + rd_num_q[ADDR_W-1:0];
               used_d   = used_after_rd;
               state_d  = StArb;
            end else if (timeout_hit) begin
               terr_d  = 1'b1;
               run_d   = 1'b0;
               state_d = StIdle;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         StDrainChk: begin
            state_d = (used_q == '0) ? StIdle : StArb;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Stop request: never aborts a burst, only blocks new writes and enables flushing.
      if ((state_q != StIdle) && !iRunStart) begin
         run_d   = 1'b0;
         drain_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         used_q     <= '0;
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         wr_num_q   <= '0;
         rd_num_q   <= '0;
         wr_start_q <= 1'b0;
         rd_start_q <= 1'b0;
         run_q      <= 1'b0;
         drain_q    <= 1'b0;
         terr_q     <= 1'b0;
         last_wr_q  <= 1'b0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         used_q     <= used_d;
         wr_addr_q  <= wr_addr_d;
         rd_addr_q  <= rd_addr_d;
         wr_num_q   <= wr_num_d;
         rd_num_q   <= rd_num_d;
         wr_start_q <= wr_start_d;
         rd_start_q <= rd_start_d;
         run_q      <= run_d;
         drain_q    <= drain_d;
         terr_q     <= terr_d;
         last_wr_q  <= last_wr_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign WR_iRunStart   = wr_start_q;
   assign RD_iRunStart   = rd_start_q;
   assign WR_START_ADDR  = wr_addr_q;
   assign RD_START_ADDR  = rd_addr_q;
   assign WR_DATA_NUM    = wr_num_q;
   assign RD_DATA_NUM    = rd_num_q;
   assign Data_iRunStart = run_q;
   assign SRAM_USED_WORD = used_q;
   assign SRAM_Full      = (used_ext > DEPTH - WR_BURST);
   assign SRAM_Empty     = (used_q == '0);
   assign Timeout_Err    = terr_q;

endmodule

// File: tb/tb_sram_ring_scheduler.sv
// Bench for sram_ring_scheduler: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural model of the scheduling rules.
module tb_sram_ring_scheduler;

   localparam int DEPTH = 16384;
   localparam int WRB   = 1024;
   localparam int RDB   = 4096;
   localparam int OMAX  = 12288;
   localparam int TO    = 100;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        iRunStart = 1'b0;
   logic [10:0] SRAM_FIFO_usedw = '0;
   logic [13:0] USB_FIFO_usedw = '0;
   logic        WR_RunEnd, RD_RunEnd;
   logic        eng_wr = 1'b0, eng_rd = 1'b0, stray_wr = 1'b0, stray_rd = 1'b0;
   logic        WR_iRunStart, RD_iRunStart, Data_iRunStart;
   logic [13:0] WR_START_ADDR, RD_START_ADDR;
   logic [14:0] WR_DATA_NUM, RD_DATA_NUM, SRAM_USED_WORD;
   logic        SRAM_Full, SRAM_Empty, Timeout_Err;

   assign WR_RunEnd = eng_wr | stray_wr;
   assign RD_RunEnd = eng_rd | stray_rd;

   sram_ring_scheduler #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .iRunStart(iRunStart),
      .SRAM_FIFO_usedw(SRAM_FIFO_usedw), .USB_FIFO_usedw(USB_FIFO_usedw),
      .WR_RunEnd(WR_RunEnd), .RD_RunEnd(RD_RunEnd),
      .WR_iRunStart(WR_iRunStart), .RD_iRunStart(RD_iRunStart),
      .WR_START_ADDR(WR_START_ADDR), .RD_START_ADDR(RD_START_ADDR),
      .WR_DATA_NUM(WR_DATA_NUM), .RD_DATA_NUM(RD_DATA_NUM),
      .Data_iRunStart(Data_iRunStart), .SRAM_USED_WORD(SRAM_USED_WORD),
      .SRAM_Full(SRAM_Full), .SRAM_Empty(SRAM_Empty), .Timeout_Err(Timeout_Err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [78:0] act, input logic [78:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [78:0] dut_vec();
      return {WR_iRunStart, RD_iRunStart, WR_START_ADDR, RD_START_ADDR, WR_DATA_NUM,
              RD_DATA_NUM, Data_iRunStart, SRAM_USED_WORD, SRAM_Full, SRAM_Empty, Timeout_Err};
   endfunction

   // ---------------- behavioural model ----------------
   // Activity: 0 stopped, 1 choosing next burst, 2 writing, 3 reading, 4 checking drain done.
   int  m_act = 0;
   int  m_wp = 0, m_rp = 0, m_used = 0;
   int  m_waddr = 0, m_raddr = 0, m_wnum = 0, m_rnum = 0;
   int  m_wpulse = 0, m_rpulse = 0, m_run = 0, m_drain = 0, m_terr = 0;
   int  m_prev_write = 0, m_waited = 0;
   bit  can_w, can_r;

   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         m_act = 0; m_wp = 0; m_rp = 0; m_used = 0; m_waddr = 0; m_raddr = 0;
         m_wnum = 0; m_rnum = 0; m_wpulse = 0; m_rpulse = 0; m_run = 0; m_drain = 0;
         m_terr = 0; m_prev_write = 0; m_waited = 0;
      end else begin
         can_w = (m_run != 0) && (int'(SRAM_FIFO_usedw) >= WRB) && (DEPTH - m_used >= WRB);
         can_r = (int'(USB_FIFO_usedw) <= OMAX) &&
                 ((m_used >= RDB) || ((m_drain != 0) && (m_used > 0)));
         m_wpulse = 0;
         m_rpulse = 0;
         if (m_act == 0) begin
            m_drain = 0;
            if (iRunStart) begin
               m_wp = 0; m_rp = 0; m_used = 0; m_terr = 0; m_run = 1; m_act = 1;
            end
         end else begin
            if (m_act == 1) begin
               if (can_w && can_r) begin
                  // Tie: the other kind of burst than last time.
                  if (m_prev_write != 0) can_w = 0;
                  else can_r = 0;
               end
               if (can_w) begin
                  m_wpulse = 1; m_wnum = WRB; m_waddr = m_wp; m_prev_write = 1;
                  m_waited = 0; m_act = 2;
               end else if (can_r) begin
                  m_rpulse = 1; m_rnum = (m_used < RDB) ? m_used : RDB; m_raddr = m_rp;
                  m_prev_write = 0; m_waited = 0; m_act = 3;
               end else if (m_drain != 0) begin
                  m_act = 4;
               end
            end else if (m_act == 2 || m_act == 3) begin
               if ((m_act == 2 && WR_RunEnd) || (m_act == 3 && RD_RunEnd)) begin
                  if (m_act == 2) begin
                     m_wp = (m_wp + m_wnum) % DEPTH;
                     m_used = m_used + m_wnum;
                  end else begin
                     m_rp = (m_rp + m_rnum) % DEPTH;
                     m_used = m_used - m_rnum;
                  end
                  m_act = 1;
               end else begin
                  m_waited++;
                  if (m_waited == TO) begin
                     m_terr = 1; m_run = 0; m_act = 0;
                  end
               end
            end else begin
               m_act = (m_used == 0) ? 0 : 1;
            end
            if (!iRunStart) begin
               m_run = 0;
               m_drain = 1;
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   initial forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
         check("cycle", dut_vec(),
               {m_wpulse[0], m_rpulse[0], m_waddr[13:0], m_raddr[13:0], m_wnum[14:0],
                m_rnum[14:0], m_run[0], m_used[14:0], (m_used > DEPTH - WRB), (m_used == 0),
                m_terr[0]});
      end
   end

   // ---------------- SRAM engine emulation ----------------
   bit wr_en = 1'b1, rd_en = 1'b1, wr_pend = 1'b0, rd_pend = 1'b0;
   int wr_cnt = 0, rd_cnt = 0, fixed_lat = 10;

   initial forever begin
      @(negedge clk);
      eng_wr = 1'b0;
      eng_rd = 1'b0;
      if (reset) begin
         wr_pend = 1'b0;
         rd_pend = 1'b0;
      end else begin
         if (wr_pend) begin
            if (wr_cnt == 0) begin eng_wr = 1'b1; wr_pend = 1'b0; end
            else wr_cnt--;
         end
         if (rd_pend) begin
            if (rd_cnt == 0) begin eng_rd = 1'b1; rd_pend = 1'b0; end
            else rd_cnt--;
         end
         if (WR_iRunStart && wr_en) begin
            wr_pend = 1'b1;
            wr_cnt = ((fixed_lat > 0) ? fixed_lat : int'($urandom_range(30, 1))) - 1;
         end
         if (RD_iRunStart && rd_en) begin
            rd_pend = 1'b1;
            rd_cnt = ((fixed_lat > 0) ? fixed_lat : int'($urandom_range(30, 1))) - 1;
         end
      end
   end

   // ---------------- burst monitor ----------------
   int    n_wr = 0, n_rd = 0, wide = 0;
   int    wr_addrs[$];
   int    rd_addr_first = -1, rd_num_first = -1, used_at_rd = -1;
   string grants = "";
   bit    prev_w = 1'b0, prev_r = 1'b0;

   initial forever begin
      @(negedge clk);
      if (WR_iRunStart) begin
         if (prev_w) wide++;
         else begin
            n_wr++;
            if (wr_addrs.size() < 32) wr_addrs.push_back(int'(WR_START_ADDR));
            if (grants.len() < 32) grants = {grants, "W"};
         end
      end
      if (RD_iRunStart) begin
         if (prev_r) wide++;
         else begin
            if (n_rd == 0) begin
               rd_addr_first = int'(RD_START_ADDR);
               rd_num_first  = int'(RD_DATA_NUM);
               used_at_rd    = int'(SRAM_USED_WORD);
            end
            n_rd++;
            if (grants.len() < 32) grants = {grants, "R"};
         end
      end
      prev_w = WR_iRunStart;
      prev_r = RD_iRunStart;
   end

   // Bounded wait; an expired bound counts as a failed comparison.
   task automatic wait_until(input int sel, input int target, input int bound, input string name);
      bit hit = 1'b0;
      for (int i = 0; i < bound && !hit; i++) begin
         @(negedge clk);
         case (sel)
            0: hit = WR_iRunStart;
            1: hit = RD_iRunStart;
            2: hit = (int'(SRAM_USED_WORD) == target);
            3: hit = SRAM_Empty;
            default: hit = (wr_addrs.size() >= target);
         endcase
      end
      checks++;
      if (!hit) begin
         failures++;
         $display("FAIL %s got=no event want=event within %0d cycles", name, bound);
      end
   endtask

   initial begin
      #(2_000_000);
      $display("FAIL watchdog got=no finish want=finish");
      $fatal(1, "watchdog");
   end

   int snap;
   int k;

   initial begin
      // Reset state.
      #2 reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_empty", SRAM_Empty, 1);
      check("rst_full", SRAM_Full, 0);
      check("rst_used", SRAM_USED_WORD, 0);
      check("rst_run", Data_iRunStart, 0);
      check("rst_terr", Timeout_Err, 0);
      check("rst_wr_num", WR_DATA_NUM, 0);
      @(negedge clk);
      reset = 1'b0;

      // Fixed 10-cycle engines, input FIFO always holds one burst.
      iRunStart = 1'b1;
      SRAM_FIFO_usedw = 11'd1024;
      USB_FIFO_usedw = '0;
      wait_until(4, 17, 3000, "seventeen_writes");
      check("wr_addr0", wr_addrs[0], 0);
      check("wr_addr1", wr_addrs[1], 1024);
      check("wr_addr2", wr_addrs[2], 2048);
      check("wr_addr3", wr_addrs[3], 3072);
      check("wr_addr_wrap_hi", wr_addrs[15], 15360);
      check("wr_addr_wrap_lo", wr_addrs[16], 0);
      check("rd_first_addr", rd_addr_first, 0);
      check("rd_first_num", rd_num_first, 4096);
      check("used_at_first_rd", used_at_rd, 4096);
      check("pulse_width", wide, 0);
      checks++;
      if (grants.substr(0, 9) != "WWWWRWWWWR") begin
         failures++;
         $display("FAIL grant_order got=%s want=WWWWRWWWWR", grants.substr(0, 9));
      end

      // Output FIFO too full: SRAM fills completely and then everything stalls.
      USB_FIFO_usedw = 14'd12289;
      wait_until(2, 16384, 3000, "fill_to_depth");
      snap = n_wr + n_rd;
      repeat (20) @(negedge clk);
      check("stall_no_bursts", n_wr + n_rd, snap);
      check("full_flag", SRAM_Full, 1);
      USB_FIFO_usedw = 14'd12288;
      @(negedge clk);
      check("rd_after_unblock", RD_iRunStart, 1);
      check("rd_num_after_unblock", RD_DATA_NUM, 4096);

      // Stop with 1024 words stored: one short read, then back to idle.
      reset = 1'b1;
      iRunStart = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      iRunStart = 1'b1;
      SRAM_FIFO_usedw = 11'd1024;
      USB_FIFO_usedw = 14'd12289;
      wait_until(0, 0, 50, "drain_setup_write");
      SRAM_FIFO_usedw = '0;
      wait_until(2, 1024, 100, "drain_setup_used");
      snap = n_rd;
      iRunStart = 1'b0;
      USB_FIFO_usedw = '0;
      @(negedge clk);
      check("drain_run_off", Data_iRunStart, 0);
      wait_until(1, 0, 20, "drain_read");
      check("drain_rd_num", RD_DATA_NUM, 1024);
      wait_until(3, 0, 100, "drain_empty");
      repeat (5) @(negedge clk);
      check("drain_one_read", n_rd - snap, 1);
      check("drain_empty_flag", SRAM_Empty, 1);

      // Write engine never answers: timeout after 100 wait cycles.
      wr_en = 1'b0;
      SRAM_FIFO_usedw = 11'd1024;
      USB_FIFO_usedw = 14'd12289;
      iRunStart = 1'b1;
      wait_until(0, 0, 20, "timeout_write");
      k = 0;
      while (!Timeout_Err && k < 300) begin
         @(negedge clk);
         k++;
         if (k == 3) iRunStart = 1'b0;
      end
      check("timeout_cycle", k, TO);
      check("timeout_run", Data_iRunStart, 0);
      check("timeout_used", SRAM_USED_WORD, 0);
      repeat (5) @(negedge clk);
      check("timeout_sticky", Timeout_Err, 1);
      wr_en = 1'b1;
      iRunStart = 1'b1;
      @(negedge clk);
      check("timeout_cleared", Timeout_Err, 0);

      // Reset in the middle of a read burst, then a stray completion.
      rd_en = 1'b0;
      USB_FIFO_usedw = '0;
      wait_until(1, 0, 500, "reset_read");
      @(negedge clk);
      reset = 1'b1;
      iRunStart = 1'b0;
      #1;
      check("reset_mid_burst", dut_vec(), 79'h2);
      @(negedge clk);
      reset = 1'b0;
      snap = n_wr + n_rd;
      stray_rd = 1'b1;
      @(negedge clk);
      stray_rd = 1'b0;
      repeat (10) @(negedge clk);
      check("stray_used", SRAM_USED_WORD, 0);
      check("stray_no_bursts", n_wr + n_rd, snap);
      rd_en = 1'b1;

      // Randomized traffic.
      fixed_lat = 0;
      iRunStart = 1'b1;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         if (c == 2500) reset = 1'b1;
         if (c == 2502) reset = 1'b0;
         stray_wr = ($urandom_range(63, 0) == 0);
         stray_rd = ($urandom_range(63, 0) == 0);
         if (iRunStart) begin
            if ($urandom_range(399, 0) == 0) iRunStart = 1'b0;
         end else if ($urandom_range(19, 0) == 0) begin
            iRunStart = 1'b1;
         end
         if ($urandom_range(15, 0) == 0) SRAM_FIFO_usedw = 11'($urandom_range(2047, 0));
         if ($urandom_range(15, 0) == 0) begin
            if ($urandom_range(1, 0) == 0) USB_FIFO_usedw = 14'($urandom_range(12400, 12200));
            else USB_FIFO_usedw = 14'($urandom_range(16383, 0));
         end
      end
      stray_wr = 1'b0;
      stray_rd = 1'b0;
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
